riscv_core_branch_predictor: RTL and testbench

Dynamic branch predictor sitting directly upstream of the next-PC selection logic. It feeds that logic its prediction inputs (valid, isTaken, predictedAddr) and its recovery inputs (misprediction, recoveredAddr).
- Lookup: direct-mapped BTB with per-entry 2-bit saturating counters, indexed by the fetch PC, combinational in the same cycle.
- Update: trained by resolved branches/jumps from execute on the clock edge. The same resolution is compared against the prediction carried down the pipeline to flag mispredictions.

---
 rtl/riscv_core_branch_predictor.sv | 136 +++++++++++++
 tb/tb_riscv_core_branch_predictor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, combinational lookup,
// edge-trained update and same-cycle misprediction/recovery generation.
module riscv_core_branch_predictor #(
    parameter int ADDRLEN = 64,
    parameter int ENTRIES = 64,
    localparam int IDXLEN = $clog2(ENTRIES)
) (
    input  logic               i_branch_predictor_clk,
    input  logic               i_branch_predictor_rst,
    input  logic [ADDRLEN-1:0] i_branch_predictor_fetch_PC,
    output logic               o_branch_predictor_valid,
    output logic               o_branch_predictor_isTaken,
    output logic [ADDRLEN-1:0] o_branch_predictor_predictedAddr,
    input  logic               i_branch_predictor_update_en,
    input  logic [ADDRLEN-1:0] i_branch_predictor_update_PC,
    input  logic               i_branch_predictor_update_is_jump,
    input  logic               i_branch_predictor_update_taken,
    input  logic [ADDRLEN-1:0] i_branch_predictor_update_target,
    input  logic               i_branch_predictor_update_is_compressed,
    input  logic               i_branch_predictor_update_pred_taken,
    input  logic [ADDRLEN-1:0] i_branch_predictor_update_pred_addr,
    output logic               o_branch_predictor_misprediction,
    output logic [ADDRLEN-1:0] o_branch_predictor_recoveredAddr
);

    localparam int TAGLEN = ADDRLEN - IDXLEN - 1;

    logic               valid_q  [ENTRIES];
    logic               valid_d  [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic               jump_q   [ENTRIES];
    logic               jump_d   [ENTRIES];
    logic [TAGLEN-1:0]  tag_q    [ENTRIES];
    logic [TAGLEN-1:0]  tag_d    [ENTRIES];
    logic [ADDRLEN-1:0] target_q [ENTRIES];
    logic [ADDRLEN-1:0] target_d [ENTRIES];

    logic [IDXLEN-1:0]  f_idx;
    logic [TAGLEN-1:0]  f_tag;
    logic               f_hit;
    logic [IDXLEN-1:0]  u_idx;
    logic [TAGLEN-1:0]  u_tag;
    logic               u_hit;
    logic               upd_live;
    logic               mis_raw;
    logic [ADDRLEN-1:0] fallthrough;
    logic               unused_pc_bit0;

    // Halfword-aligned PCs: bit 0 never participates in index or tag.
    assign unused_pc_bit0 = i_branch_predictor_fetch_PC[0];

    assign f_idx = i_branch_predictor_fetch_PC[IDXLEN:1];
    assign f_tag = i_branch_predictor_fetch_PC[ADDRLEN-1:IDXLEN+1];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign u_idx = i_branch_predictor_update_PC[IDXLEN:1];
    assign u_tag = i_branch_predictor_update_PC[ADDRLEN-1:IDXLEN+1];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_comb begin
        o_branch_predictor_valid         = 1'b0;
        o_branch_predictor_isTaken       = 1'b0;
        o_branch_predictor_predictedAddr = '0;
        if (!i_branch_predictor_rst && f_hit) begin
            o_branch_predictor_valid         = 1'b1;
            o_branch_predictor_isTaken       = ctr_q[f_idx][1] | jump_q[f_idx];
            o_branch_predictor_predictedAddr = target_q[f_idx];
        end
    end

    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        jump_d   = jump_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (i_branch_predictor_update_en) begin
            if (u_hit) begin
                if (i_branch_predictor_update_taken) begin
                    if (ctr_q[u_idx] != 2'b11) begin
                        ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
                    end
                    target_d[u_idx] = i_branch_predictor_update_target;
                    jump_d[u_idx]   = i_branch_predictor_update_is_jump;
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
                end
            end else if (i_branch_predictor_update_taken) begin
                // Jumps allocate strongly taken, branches weakly taken.
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = i_branch_predictor_update_target;
                jump_d[u_idx]   = i_branch_predictor_update_is_jump;
                ctr_d[u_idx]    = i_branch_predictor_update_is_jump ?
                                  2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge i_branch_predictor_clk or posedge i_branch_predictor_rst) begin
        if (i_branch_predictor_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
                jump_q[i]  <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
            jump_q  <= jump_d;
        end
    end

    // Tag and target are qualified by valid, so they carry no reset.
    always_ff @(posedge i_branch_predictor_clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign upd_live    = i_branch_predictor_update_en && !i_branch_predictor_rst;
    assign fallthrough = i_branch_predictor_update_PC +
                         (i_branch_predictor_update_is_compressed ?
                          ADDRLEN'(2) : ADDRLEN'(4));
    assign mis_raw =
        (i_branch_predictor_update_taken != i_branch_predictor_update_pred_taken) ||
        (i_branch_predictor_update_taken && i_branch_predictor_update_pred_taken &&
         (i_branch_predictor_update_pred_addr != i_branch_predictor_update_target));

    assign o_branch_predictor_misprediction = upd_live && mis_raw;
    assign o_branch_predictor_recoveredAddr =
        !upd_live ? '0 :
        i_branch_predictor_update_taken ? i_branch_predictor_update_target :
        fallthrough;

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Bench for riscv_core_branch_predictor: directed table, reset corner
// sequence, then randomized traffic against a behavioural BTB model.
module tb_riscv_core_branch_predictor;

    localparam int AL = 64;
    localparam int EN = 64;
    localparam int IL = $clog2(EN);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AL-1:0] fetch_pc = '0;
    logic          upd_en = 1'b0;
    logic [AL-1:0] upd_pc = '0;
    logic          upd_jump = 1'b0;
    logic          upd_taken = 1'b0;
    logic [AL-1:0] upd_tgt = '0;
    logic          upd_comp = 1'b0;
    logic          pred_taken = 1'b0;
    logic [AL-1:0] pred_addr = '0;
    logic          o_valid;
    logic          o_taken;
    logic [AL-1:0] o_addr;
    logic          o_mis;
    logic [AL-1:0] o_rec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    riscv_core_branch_predictor #(.ADDRLEN(AL), .ENTRIES(EN)) dut (
        .i_branch_predictor_clk                 (clk),
        .i_branch_predictor_rst                 (rst),
        .i_branch_predictor_fetch_PC            (fetch_pc),
        .o_branch_predictor_valid               (o_valid),
        .o_branch_predictor_isTaken             (o_taken),
        .o_branch_predictor_predictedAddr       (o_addr),
        .i_branch_predictor_update_en           (upd_en),
        .i_branch_predictor_update_PC           (upd_pc),
        .i_branch_predictor_update_is_jump      (upd_jump),
        .i_branch_predictor_update_taken        (upd_taken),
        .i_branch_predictor_update_target       (upd_tgt),
        .i_branch_predictor_update_is_compressed(upd_comp),
        .i_branch_predictor_update_pred_taken   (pred_taken),
        .i_branch_predictor_update_pred_addr    (pred_addr),
        .o_branch_predictor_misprediction       (o_mis),
        .o_branch_predictor_recoveredAddr       (o_rec)
    );

    task automatic check(input string name, input logic [AL-1:0] got,
                         input logic [AL-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Behavioural model: table keyed by (pc/2) mod EN, tag = pc / (2*EN).
    bit              m_valid [EN];
    longint unsigned m_tag   [EN];
    longint unsigned m_tgt   [EN];
    int              m_ctr   [EN];
    bit              m_jump  [EN];

    function automatic void model_reset();
        for (int i = 0; i < EN; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
            m_jump[i]  = 0;
        end
    endfunction

    function automatic int m_idx(input longint unsigned pc);
        return int'((pc / 2) % EN);
    endfunction

    function automatic longint unsigned m_tagof(input longint unsigned pc);
        return pc / (2 * EN);
    endfunction

    function automatic bit m_hit(input longint unsigned pc);
        return m_valid[m_idx(pc)] && m_tag[m_idx(pc)] == m_tagof(pc);
    endfunction

    function automatic void model_update();
        int i;
        i = m_idx(upd_pc);
        if (!upd_en) return;
        if (m_hit(upd_pc)) begin
            if (upd_taken) begin
                m_ctr[i]  = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i]  = upd_tgt;
                m_jump[i] = upd_jump;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (upd_taken) begin
            m_valid[i] = 1;
            m_tag[i]   = m_tagof(upd_pc);
            m_tgt[i]   = upd_tgt;
            m_jump[i]  = upd_jump;
            m_ctr[i]   = upd_jump ? 3 : 2;
        end
    endfunction

    typedef struct {
        logic [AL-1:0] fpc;
        logic          en;
        logic [AL-1:0] upc;
        logic          j;
        logic          t;
        logic [AL-1:0] tgt;
        logic          c;
        logic          pt;
        logic [AL-1:0] pa;
        logic          ev;
        logic          et;
        logic [AL-1:0] ea;
        logic          em;
        logic [AL-1:0] er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [AL-1:0] fpc, input logic en, input logic [AL-1:0] upc,
        input logic j, input logic t, input logic [AL-1:0] tgt,
        input logic c, input logic pt, input logic [AL-1:0] pa,
        input logic ev, input logic et, input logic [AL-1:0] ea,
        input logic em, input logic [AL-1:0] er);
        vec_t v;
        v.fpc = fpc; v.en = en; v.upc = upc; v.j = j; v.t = t; v.tgt = tgt;
        v.c = c; v.pt = pt; v.pa = pa; v.ev = ev; v.et = et; v.ea = ea;
        v.em = em; v.er = er;
        return v;
    endfunction

    localparam logic [AL-1:0] A  = 64'h8000_0010;
    localparam logic [AL-1:0] T  = 64'h8000_0100;
    localparam logic [AL-1:0] B  = 64'h8000_0090;
    localparam logic [AL-1:0] TB = 64'h8000_0200;
    localparam logic [AL-1:0] AF = 64'h8000_0014;

    initial begin
        // reset / allocate / saturate
        tbl.push_back(mk(A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(A, 1, A, 0, 1, T, 0, 0, 0, 0, 0, 0, 1, T));
        tbl.push_back(mk(A, 1, A, 0, 1, T, 0, 1, T, 1, 1, T, 0, T));
        tbl.push_back(mk(A, 1, A, 0, 1, T, 0, 1, T, 1, 1, T, 0, T));
        tbl.push_back(mk(A, 1, A, 0, 0, T, 0, 1, T, 1, 1, T, 1, AF));
        tbl.push_back(mk(A, 1, A, 0, 0, T, 0, 1, T, 1, 1, T, 1, AF));
        tbl.push_back(mk(A, 1, A, 0, 0, T, 0, 0, 0, 1, 0, T, 0, AF));
        tbl.push_back(mk(A, 1, A, 0, 0, T, 0, 0, 0, 1, 0, T, 0, AF));
        tbl.push_back(mk(A, 1, A, 0, 1, T, 0, 0, 0, 1, 0, T, 1, T));
        tbl.push_back(mk(A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, T, 0, 0));
        // aliasing
        tbl.push_back(mk(A, 1, B, 0, 1, TB, 0, 0, 0, 1, 0, T, 1, TB));
        tbl.push_back(mk(A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(B, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, TB, 0, 0));
        tbl.push_back(mk(B, 1, A, 0, 0, T, 0, 0, 0, 1, 1, TB, 0, AF));
        tbl.push_back(mk(A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // recovery addresses
        tbl.push_back(mk(0, 1, 64'h1000, 0, 0, 64'h3000, 1, 1, 64'h2000,
                         0, 0, 0, 1, 64'h1002));
        tbl.push_back(mk(0, 1, 64'h1000, 0, 0, 64'h3000, 0, 1, 64'h2000,
                         0, 0, 0, 1, 64'h1004));
        tbl.push_back(mk(0, 1, 64'h1000, 0, 1, 64'h3000, 0, 1, 64'h2000,
                         0, 0, 0, 1, 64'h3000));
        tbl.push_back(mk(64'h1000, 0, 0, 0, 0, 0, 0, 0, 0,
                         1, 1, 64'h3000, 0, 0));
        // JAL stays taken
        tbl.push_back(mk(64'h400, 1, 64'h400, 1, 1, 64'h800, 0, 0, 0,
                         0, 0, 0, 1, 64'h800));
        tbl.push_back(mk(64'h400, 1, 64'h400, 1, 0, 64'h800, 0, 1, 64'h800,
                         1, 1, 64'h800, 1, 64'h404));
        tbl.push_back(mk(64'h400, 1, 64'h400, 1, 0, 64'h800, 0, 1, 64'h800,
                         1, 1, 64'h800, 1, 64'h404));
        tbl.push_back(mk(64'h400, 0, 0, 0, 0, 0, 0, 0, 0,
                         1, 1, 64'h800, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            fetch_pc = tbl[i].fpc; upd_en = tbl[i].en; upd_pc = tbl[i].upc;
            upd_jump = tbl[i].j; upd_taken = tbl[i].t; upd_tgt = tbl[i].tgt;
            upd_comp = tbl[i].c; pred_taken = tbl[i].pt; pred_addr = tbl[i].pa;
            #1;
            check($sformatf("vec%0d_valid", i), AL'(o_valid), AL'(tbl[i].ev));
            check($sformatf("vec%0d_taken", i), AL'(o_taken), AL'(tbl[i].et));
            check($sformatf("vec%0d_addr", i), o_addr, tbl[i].ea);
            check($sformatf("vec%0d_mis", i), AL'(o_mis), AL'(tbl[i].em));
            check($sformatf("vec%0d_rec", i), o_rec, tbl[i].er);
        end

        // asynchronous reset mid-cycle, pending update discarded
        @(negedge clk);
        upd_en = 1'b0;
        fetch_pc = 64'h400;
        #1 check("pre_rst_valid", AL'(o_valid), AL'(1));
        #1 rst = 1'b1;
        #1;
        check("rst_valid", AL'(o_valid), AL'(0));
        check("rst_taken", AL'(o_taken), AL'(0));
        check("rst_addr", o_addr, 0);
        upd_en = 1'b1; upd_pc = 64'h600; upd_jump = 1'b0; upd_taken = 1'b1;
        upd_tgt = 64'h900; upd_comp = 1'b0; pred_taken = 1'b0; pred_addr = 0;
        #1;
        check("rst_mis", AL'(o_mis), AL'(0));
        check("rst_rec", o_rec, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_jal_miss", AL'(o_valid), AL'(0));
        check("post_rst_mis", AL'(o_mis), AL'(1));
        check("post_rst_rec", o_rec, 64'h900);
        fetch_pc = 64'h600;
        #1 check("discarded_upd_miss", AL'(o_valid), AL'(0));
        @(posedge clk);
        @(negedge clk);
        upd_en = 1'b0;
        #1;
        check("first_edge_valid", AL'(o_valid), AL'(1));
        check("first_edge_taken", AL'(o_taken), AL'(1));
        check("first_edge_addr", o_addr, 64'h900);

        // randomized traffic against the model
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            longint unsigned base;
            bit              me;
            longint unsigned exp_rec;
            int              fi;
            @(negedge clk);
            base = ($urandom_range(0, 1) == 0) ? 64'h8000_0000 : 64'h8000_1000;
            fetch_pc = base + 2 * $urandom_range(0, 127) + $urandom_range(0, 1);
            base = ($urandom_range(0, 1) == 0) ? 64'h8000_0000 : 64'h8000_1000;
            upd_pc = base + 2 * $urandom_range(0, 127);
            if ($urandom_range(0, 49) == 0) upd_pc = 64'hFFFF_FFFF_FFFF_FFFE;
            upd_en    = ($urandom_range(0, 3) != 0);
            upd_jump  = ($urandom_range(0, 4) == 0);
            upd_taken = upd_jump | ($urandom_range(0, 1) == 1);
            upd_tgt   = 64'h9000_0000 + 2 * $urandom_range(0, 7);
            upd_comp  = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1 && m_hit(upd_pc)) begin
                pred_taken = m_ctr[m_idx(upd_pc)] >= 2 || m_jump[m_idx(upd_pc)];
                pred_addr  = m_tgt[m_idx(upd_pc)];
            end else begin
                pred_taken = $urandom_range(0, 1);
                pred_addr  = 64'h9000_0000 + 2 * $urandom_range(0, 7);
            end
            #1;
            fi = m_idx(fetch_pc);
            check("rnd_valid", AL'(o_valid), AL'(m_hit(fetch_pc)));
            check("rnd_taken", AL'(o_taken),
                  AL'(m_hit(fetch_pc) && (m_ctr[fi] >= 2 || m_jump[fi])));
            check("rnd_addr", o_addr, m_hit(fetch_pc) ? m_tgt[fi] : 0);
            me = upd_en && ((upd_taken != pred_taken) ||
                            (upd_taken && pred_taken && pred_addr != upd_tgt));
            exp_rec = !upd_en ? 0 : upd_taken ? upd_tgt :
                      upd_pc + (upd_comp ? 2 : 4);
            check("rnd_mis", AL'(o_mis), AL'(me));
            check("rnd_rec", o_rec, exp_rec);
            @(posedge clk);
            model_update();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
